mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous memory between an instruction
// fetch port and a load/store port. Grants are combinational from the
// same-cycle requests. The data port has priority, but a waiting fetch is
// granted once STARVE_LIMIT consecutive data grants have gone by.
// Read data returns exactly one cycle after the grant and is steered to the
// port that owned that grant.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// OWN_NONE    | no access was granted last cycle; no response this cycle
// OWN_INSTR   | last cycle granted a fetch; mem_rdata_i goes to the instr port
// OWN_DATA_RD | last cycle granted a load; mem_rdata_i goes to the data port
// OWN_DATA_WR | last cycle granted a store; acknowledge with zero data
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_req_i,
  input  logic [ADDRESS_WIDTH-1:0] instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]    instr_rdata_o,
  input  logic                     data_req_i,
  input  logic                     data_we_i,
  input  logic [3:0]               data_be_i,
  input  logic [ADDRESS_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0]    data_wdata_i,
  output logic                     data_gnt_o,
  output logic                     data_rvalid_o,
  output logic [DATA_WIDTH-1:0]    data_rdata_o,
  output logic                     mem_en_o,
  output logic                     mem_we_o,
  output logic [3:0]               mem_be_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [ADDRESS_WIDTH-1:0] BYTE_MASK = ADDRESS_WIDTH'(3);

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INSTR   = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_DATA_WR = 2'd3
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          instr_gnt, data_gnt;

  // Arbitration: data first unless the fetch has waited its limit; nothing during reset.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!rst_i) begin
      if (instr_req_i && (!data_req_i || starve_q == LIMIT)) begin
        instr_gnt = 1'b1;
      end else if (data_req_i) begin
        data_gnt = 1'b1;
      end
    end
  end

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;
  assign mem_en_o    = instr_gnt | data_gnt;

  // Memory command for the granted port; all zero when idle.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (instr_gnt) begin
      mem_be_o   = 4'hF;
      mem_addr_o = instr_addr_i & ~BYTE_MASK;
    end else if (data_gnt) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_we_i ? data_be_i : 4'hF;
      mem_addr_o  = data_addr_i & ~BYTE_MASK;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Next starve count and next response owner.
  always_comb begin
    starve_d = starve_q;
    if (instr_gnt || !instr_req_i) begin
      starve_d = '0;
    end else if (data_gnt && starve_q != LIMIT) begin
      starve_d = starve_q + CW'(1);
    end

    owner_d = OWN_NONE;
    if (instr_gnt) begin
      owner_d = OWN_INSTR;
    end else if (data_gnt) begin
      owner_d = data_we_i ? OWN_DATA_WR : OWN_DATA_RD;
    end
  end

  // Owner FSM and starve counter; reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Response steering; held silent while reset is asserted.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    if (!rst_i) begin
      case (owner_q)
        OWN_INSTR: begin
          instr_rvalid_o = 1'b1;
          instr_rdata_o  = mem_rdata_i;
        end
        OWN_DATA_RD: begin
          data_rvalid_o = 1'b1;
          data_rdata_o  = mem_rdata_i;
        end
        OWN_DATA_WR: begin
          data_rvalid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
